sram_access_seq: RTL

- Downstream consumer of the memory-control FSM's rw/valid outputs.
- Turns each FSM access request into a timed precharge / wordline / write-or-sense sequence on a small word-organised SRAM array, modelled internally.
- Returns read data with a one-cycle strobe.
- Asserts busy while a sequence is in flight.

---
 rtl/sram_access_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sram_access_seq.sv
// Sequencer that turns FSM rw/valid requests into precharge / wordline / write-or-sense
// cycles on a small internal word-organised SRAM. Optional parity: define SRAM_PARITY_EN.
module sram_access_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rw,
  input  logic                      valid,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      pre,
  output logic [(2**ADDR_W)-1:0]    wl,
  output logic                      we
`ifdef SRAM_PARITY_EN
  , output logic                    parity_err
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [DEPTH-1:0] WL_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PRECHARGE, ACCESS, SENSE} state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic                accept;
  logic                cap_rw_q;
  logic [ADDR_W-1:0]   cap_addr_q;
  logic [DATA_W-1:0]   cap_din_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   dout_q;
  logic                dout_valid_q;

  function automatic logic even_par(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // A request is taken only from IDLE and only once per valid-high episode.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && armed_q) begin
          accept  = 1'b1;
          state_d = PRECHARGE;
        end
      end
      PRECHARGE: state_d = ACCESS;
      ACCESS:    state_d = cap_rw_q ? IDLE : SENSE;
      SENSE:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (!valid) begin
      armed_d = 1'b1;
    end else if (accept) begin
      armed_d = 1'b0;
    end
  end

  assign busy = (state_q != IDLE);
  assign pre  = (state_q == PRECHARGE);
  assign wl   = ((state_q == ACCESS) || (state_q == SENSE)) ? (WL_ONE << cap_addr_q) : '0;
  assign we   = (state_q == ACCESS) && cap_rw_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef SRAM_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             parity_err_q;
  assign parity_err = parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_rw_q     <= 1'b0;
      cap_addr_q   <= '0;
      cap_din_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef SRAM_PARITY_EN
      par_q        <= '0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      dout_valid_q <= 1'b0;
`ifdef SRAM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (accept) begin
        cap_rw_q   <= rw;
        cap_addr_q <= addr;
        cap_din_q  <= din;
      end
      // Write commits as ACCESS ends; reads latch the word as SENSE ends.
      if ((state_q == ACCESS) && cap_rw_q) begin
        mem_q[cap_addr_q] <= cap_din_q;
`ifdef SRAM_PARITY_EN
        par_q[cap_addr_q] <= even_par(cap_din_q);
`endif
      end
      if (state_q == SENSE) begin
        dout_q       <= mem_q[cap_addr_q];
        dout_valid_q <= 1'b1;
`ifdef SRAM_PARITY_EN
        parity_err_q <= even_par(mem_q[cap_addr_q]) != par_q[cap_addr_q];
`endif
      end
    end
  end

endmodule
